// File: rtl/hazard_scheduler_pkg.sv
// Shared types and constants for the decode-side hazard scheduler.
// Stats widths are consumed only when HAZARD_SCHEDULER_STATS_EN is defined.
package hazard_scheduler_pkg;

  typedef logic [4:0]  tag_t;
  typedef logic [31:0] word_t;

  // Bit positions inside the decoder's range_instrs control word.
  localparam int RI_WRITE_RD_BIT = 0;
  localparam int RI_USE_RS2_BIT  = 1;
  localparam int RI_DO_LOAD_BIT  = 2;

  localparam int LOAD_LAT_DEFAULT = 2;
  localparam int ALU_LAT_DEFAULT  = 0;

  localparam int STATS_STALL_CYCLES_W = 32;
  localparam int STATS_LOAD_USE_W     = 32;

  // Countdown width; never below one bit so a fully-forwarded build still elaborates.
  function automatic int cw_for(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/hazard_scheduler_scoreboard_entry.sv
// One scoreboard slot: a countdown that loads on issue, decays each
// unfrozen cycle and freezes while the pipeline is held.
module scoreboard_entry #(
  parameter int CW = 2
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          hold_i,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  output logic [CW-1:0] count_o
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (hold_i) begin
      count_d = count_q;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_scheduler.sv
// Decode-stage issue/stall controller with a per-register result scoreboard.
// Optional counters: define HAZARD_SCHEDULER_STATS_EN.
module hazard_scheduler
  import hazard_scheduler_pkg::*;
#(
  parameter int LOAD_LAT = LOAD_LAT_DEFAULT,
  parameter int ALU_LAT  = ALU_LAT_DEFAULT,
  localparam int CW      = cw_for(LOAD_LAT, ALU_LAT)
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        dec_valid,
  input  tag_t        dec_rs1,
  input  tag_t        dec_rs2,
  input  logic        dec_use_rs1,
  input  logic        dec_use_rs2,
  input  tag_t        dec_rd,
  input  logic        dec_write_rd,
  input  logic        dec_is_load,
  input  logic        hold,
  input  logic        flush,
`ifdef HAZARD_SCHEDULER_STATS_EN
  input  logic        stats_clear,
  output logic [STATS_STALL_CYCLES_W-1:0] stall_cycles,
  output logic [STATS_LOAD_USE_W-1:0]     load_use_events,
`endif
  output logic        stall,
  output logic        issue,
  output logic        bubble,
  output logic [31:0] busy_mask
);

  logic [CW-1:0] cnt_s [32];
  logic [31:0]   busy_s;
  logic [31:0]   wr_sel_s;
  logic [CW-1:0] load_val_s;
  logic          hazard_s;
  logic          issue_s;
  logic          wr_en_s;

  assign cnt_s[0] = '0;

  for (genvar r = 1; r < 32; r++) begin : g_entry
    scoreboard_entry #(.CW(CW)) u_entry (
      .clock      (clock),
      .reset_n    (reset_n),
      .hold_i     (hold),
      .load_i     (wr_sel_s[r]),
      .load_val_i (load_val_s),
      .count_o    (cnt_s[r])
    );
  end

  always_comb begin
    busy_s = 32'd0;
    for (int r = 1; r < 32; r++) begin
      busy_s[r] = (cnt_s[r] != '0);
    end
  end

  // busy_s[0] is constant zero, so x0 can never raise a hazard.
  assign hazard_s   = dec_valid & ((dec_use_rs1 & busy_s[dec_rs1]) |
                                   (dec_use_rs2 & busy_s[dec_rs2]));
  assign issue_s    = dec_valid & ~hold & ~flush & ~hazard_s;
  assign wr_en_s    = issue_s & dec_write_rd & (dec_rd != 5'd0);
  assign wr_sel_s   = {31'd0, wr_en_s} << dec_rd;
  assign load_val_s = dec_is_load ? CW'(LOAD_LAT) : CW'(ALU_LAT);

  // Outputs are held quiet for the whole time reset is asserted.
  assign stall     = reset_n & (hold | (hazard_s & ~flush));
  assign issue     = reset_n & issue_s;
  assign bubble    = reset_n & ~hold & ~issue_s;
  assign busy_mask = busy_s;

`ifdef HAZARD_SCHEDULER_STATS_EN
  logic [31:0] is_load_q;
  logic        was_stalling_q;
  logic [STATS_STALL_CYCLES_W-1:0] stall_cycles_q;
  logic [STATS_LOAD_USE_W-1:0]     load_use_q;
  logic        stall_evt_s;
  logic        blk_load_s;

  assign stall_evt_s = hazard_s & ~hold & ~flush;
  assign blk_load_s  = (dec_use_rs1 & busy_s[dec_rs1] & is_load_q[dec_rs1]) |
                       (dec_use_rs2 & busy_s[dec_rs2] & is_load_q[dec_rs2]);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      is_load_q      <= 32'd0;
      was_stalling_q <= 1'b0;
      stall_cycles_q <= '0;
      load_use_q     <= '0;
    end else begin
      if (!hold && wr_en_s) begin
        is_load_q[dec_rd] <= dec_is_load;
      end
      if (!hold) begin
        was_stalling_q <= hazard_s & ~flush;
      end
      if (stats_clear) begin
        stall_cycles_q <= '0;
        load_use_q     <= '0;
      end else begin
        if (stall_evt_s && (stall_cycles_q != {STATS_STALL_CYCLES_W{1'b1}})) begin
          stall_cycles_q <= stall_cycles_q + 1'b1;
        end
        if (stall_evt_s && !was_stalling_q && blk_load_s) begin
          load_use_q <= load_use_q + 1'b1;
        end
      end
    end
  end

  assign stall_cycles    = stall_cycles_q;
  assign load_use_events = load_use_q;
`endif

endmodule

// File: tb/tb_hazard_scheduler.sv
// Scoreboard bench: driver pushes expected outputs from a ready-time model,
// a negedge monitor pops and compares.
module tb_hazard_scheduler;

  localparam int LL = 2;
  localparam int AL = 0;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        dec_valid, dec_use_rs1, dec_use_rs2, dec_write_rd, dec_is_load;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        hold, flush;
  logic        stall, issue, bubble;
  logic [31:0] busy_mask;

  always #5 clock = ~clock;

  hazard_scheduler #(.LOAD_LAT(LL), .ALU_LAT(AL)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .dec_valid    (dec_valid),
    .dec_rs1      (dec_rs1),
    .dec_rs2      (dec_rs2),
    .dec_use_rs1  (dec_use_rs1),
    .dec_use_rs2  (dec_use_rs2),
    .dec_rd       (dec_rd),
    .dec_write_rd (dec_write_rd),
    .dec_is_load  (dec_is_load),
    .hold         (hold),
    .flush        (flush),
    .stall        (stall),
    .issue        (issue),
    .bubble       (bubble),
    .busy_mask    (busy_mask)
  );

  // Model: a register is forwardable once the count of unfrozen edges reaches ready_at.
  longint      ready_at [32];
  longint      act;
  logic [34:0] exp_q [$];
  logic [34:0] mon_exp, mon_got;
  int          n_cmp = 0;
  int          n_bad = 0;

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_got = {stall, issue, bubble, busy_mask};
      n_cmp++;
      if (mon_got !== mon_exp) begin
        n_bad++;
        $display("FAIL outputs t=%0t got stall/issue/bubble=%b%b%b busy=%h, expected %b%b%b busy=%h",
                 $time, mon_got[34], mon_got[33], mon_got[32], mon_got[31:0],
                 mon_exp[34], mon_exp[33], mon_exp[32], mon_exp[31:0]);
      end
    end
  end

  task automatic step(input logic rn, input logic v,
                      input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2,
                      input logic [4:0] rd, input logic wr, input logic ld,
                      input logic h, input logic f);
    logic hz, st, is, bb;
    logic [31:0] bm;
    reset_n = rn; dec_valid = v; dec_rs1 = rs1; dec_use_rs1 = u1;
    dec_rs2 = rs2; dec_use_rs2 = u2; dec_rd = rd; dec_write_rd = wr;
    dec_is_load = ld; hold = h; flush = f;
    bm = 32'd0; hz = 1'b0; st = 1'b0; is = 1'b0; bb = 1'b0;
    if (!rn) begin
      for (int r = 0; r < 32; r++) ready_at[r] = 0;
      act = 0;
    end else begin
      for (int r = 1; r < 32; r++) bm[r] = (act < ready_at[r]);
      hz = v & ((u1 & (rs1 != 5'd0) & (act < ready_at[rs1])) |
                (u2 & (rs2 != 5'd0) & (act < ready_at[rs2])));
      st = h | (hz & ~f);
      is = v & ~h & ~f & ~hz;
      bb = ~h & ~is;
    end
    exp_q.push_back({st, is, bb, bm});
    @(posedge clock);
    if (rn && !h) begin
      if (is && wr && rd != 5'd0) ready_at[rd] = act + 1 + (ld ? LL : AL);
      act++;
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; dec_valid = 1'b0; dec_rs1 = 5'd0; dec_rs2 = 5'd0;
    dec_use_rs1 = 1'b0; dec_use_rs2 = 1'b0; dec_rd = 5'd0;
    dec_write_rd = 1'b0; dec_is_load = 1'b0; hold = 1'b0; flush = 1'b0;
    @(posedge clock); #1;
    step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // load x5, then add x6,x5,x1 waits two bubbles
    step(1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // ALU write x7 then immediate reader; load x0 then reader of x0
    step(1'b1, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);

    // load x5 then a 3-cycle hold with the dependent parked in decode
    step(1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);

    // flush while the x5 hazard is pending, then flush together with hold
    step(1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (2) step(1'b1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);

    // back-to-back writers to x4 (latest wins), then reset mid-hazard on x9
    step(1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);

    // random traffic on a small register window so hazards are frequent
    repeat (1500) begin
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 9) < 8),
           5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 7)), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 9) < 4),
           ($urandom_range(0, 99) < 15),
           ($urandom_range(0, 99) < 10));
    end

    repeat (2) @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain %0d expected entries left unchecked, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_scheduler.md
Name: hazard_scheduler

Overview:
- Issue/stall controller sitting beside the decode stage of the 7-stage pipeline. It owns the decoder's stall input.
- Keeps a per-register scoreboard of in-flight results that cannot yet be forwarded: load results, and ALU results when forwarding is incomplete.
- Holds a dependent instruction in decode until its operands are forwardable, and injects bubbles downstream while it does.
- Also merges the external hold (memory wait) and branch flush into a single stall/issue decision.

Parameters:
- LOAD_LAT, 2: bubble cycles a dependent instruction needs after a load issues (covers mem1/mem2).
- ALU_LAT, 0: bubble cycles after an ALU/jump result issues. 0 means full forwarding, and no entry is written.
- CW, $clog2(max(LOAD_LAT,ALU_LAT)+1): countdown width, derived, not overridden.

Ports:
- clock, in, 1: single clock.
- reset_n, in, 1: asynchronous active-low reset.
- dec_valid, in, 1: decode holds a real instruction.
- dec_rs1, in, 5 (tag): source 1 of the instruction in decode.
- dec_rs2, in, 5 (tag): source 2 of the instruction in decode.
- dec_use_rs1, in, 1: instruction reads rs1.
- dec_use_rs2, in, 1: instruction reads rs2 (the use_rs2 decode bit).
- dec_rd, in, 5 (tag): destination register.
- dec_write_rd, in, 1: instruction writes rd (the write_rd decode bit).
- dec_is_load, in, 1: instruction is a load.
- hold, in, 1: downstream pipeline frozen this cycle.
- flush, in, 1: branch/jump redirect; the instruction in decode is squashed.
- stall, out, 1: freeze fetch and decode (feeds the decoder's stall input).
- issue, out, 1: the decode instruction advances this cycle.
- bubble, out, 1: insert a NOP into the stage after decode this cycle.
- busy_mask, out, 32: bit r set when count[r] != 0. Debug aid.

Behaviour:
- State: count[1..31], each CW bits. count[0] does not exist and always reads 0.

Reset:
- reset_n low clears every count asynchronously. Consequently stall=0, issue=0, bubble=0 and busy_mask=0.
- Reset mid-operation drops all pending hazards immediately.

Hazard and outputs (all combinational, same cycle):
- hazard = dec_valid & ((dec_use_rs1 & count[dec_rs1]!=0) | (dec_use_rs2 & count[dec_rs2]!=0)).
- Register x0 never causes a hazard.
- stall = hold | (hazard & ~flush).
- issue = dec_valid & ~hold & ~flush & ~hazard.
- bubble = ~hold & ~issue. This covers the hazard, flush and invalid-decode cases.

Sequential update (posedge clock):
- When hold=1, all counts are frozen and nothing loads.
- Otherwise every nonzero count decrements by 1.
- If issue & dec_write_rd & dec_rd!=0, count[dec_rd] loads LOAD_LAT when dec_is_load, else ALU_LAT.
- The load takes precedence over the decrement for that register. A latency of 0 writes 0.
- The hazard check uses pre-update values. An instruction reading and writing the same register therefore checks the old entry.

Timing:
- A load issued in cycle t leaves a dependent instruction stalled in t+1..t+LOAD_LAT.
- That dependent issues in t+LOAD_LAT+1, so exactly LOAD_LAT bubbles.

Boundary rules:
- flush: nothing issues, stall is forced low so fetch can redirect, and bubble=1.
- Counts of already-issued (possibly squashed) instructions keep counting. This is conservatively correct; they are never cleared early.
- flush together with hold: hold wins for counts (frozen) and stall=1.
- A back-to-back write to the same rd overwrites the entry (latest writer wins). A WAW conflict never stalls.

Optional Feature:
- Macro: HAZARD_SCHEDULER_STATS_EN.
- Defined:
  - Adds output stall_cycles (32 bits): counts cycles with hazard&~hold&~flush, saturating at 0xFFFF_FFFF.
  - Adds output load_use_events (32 bits): increments on the first cycle of each hazard episode whose blocking entry was written by a load.
  - This needs a per-register is_load flag and a 1-bit "was stalling" register.
  - Both counters reset to 0 on reset_n and clear synchronously on new input stats_clear.
- Undefined: these ports, flags and counters are absent. Core behaviour is identical.

Decomposition:
- definitions.vh keeps the tag and word typedefs and the range_instrs bit positions (write_rd, use_rs2, do_load).
- Add to it: a LOAD_LAT_DEFAULT constant and the hazard_scheduler stats field widths.
- One sub-module, scoreboard_entry: a CW-bit countdown with load/decrement/freeze, instantiated 31 times via generate.

Test Plan:
- Load x5 issues at t (LOAD_LAT=2); next instruction is add x6,x5,x1 -> stall=1 and bubble=1 at t+1 and t+2; issue=1 at t+3; busy_mask bit 5 reads 1 then 0 on the following cycle.
- ALU write to x7, then an immediate reader of x7 (ALU_LAT=0) -> no stall; busy_mask stays 0.
- Load x0, then a reader of x0 -> never stalls; count[0] is never set.
- Load x5 at t, with hold=1 during t+1..t+3, then released -> counts frozen at 2 during the hold; the dependent instruction issues 2 cycles after release; stall=1 throughout the hold.
- flush while a hazard is pending on x5 -> stall=0, issue=0, bubble=1; count[5] continues decrementing to 0.
- reset_n low asynchronously with count[9]=2 -> busy_mask=0 and stall=0 before the next clock edge. With HAZARD_SCHEDULER_STATS_EN defined, a prior 2-cycle load-use stall reads stall_cycles=2 and load_use_events=1 before reset, and both read 0 after it.
